etap_tap_ctrl: RTL
==================

# etap_tap_ctrl

- EJTAG TAP controller front end: the IEEE 1149.1 16-state FSM, the 5-bit instruction register and its decoder.
- Drives the DR strobes and the 4-bit `sel` consumed by `mux_dr`, and returns the selected DR serial data as registered `tdo`.
- Sits directly upstream of `mux_dr`; single-clock design, so `clk_dr` is a one-cycle enable, not a gated clock.

## Interface
- `IR_W`, 5: instruction register width (EJTAG).
- `IR_RESET`, 5'h01: IR value after reset / Test-Logic-Reset (IDCODE).
- `clk` in 1: TCK-domain clock; all state updates on rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `tms` in 1: test mode select, sampled every `clk`.
- `tdi` in 1: serial data in.
- `dr_tdo` in 1: serial out of selected DR (`mux_dr.s_data_out`).
- `tdo` out 1: registered serial out.
- `tdo_en` out 1: `tdo` valid/drive enable.
- `capture_dr` out 1: high in CAPTURE_DR.
- `shift_dr` out 1: high in SHIFT_DR.
- `clk_dr` out 1: DR enable, high in CAPTURE_DR or SHIFT_DR.
- `update_dr` out 1: high in UPDATE_DR.
- `sel` out 4: DR select to `mux_dr`.
- `ir` out IR_W: current latched instruction.
- `tlr` out 1: high in TEST_LOGIC_RESET.

## Operation
- FSM states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, and the IR equivalents SEL_IR … UPD_IR.
- Transitions follow IEEE 1149.1 on `tms`:
  - TLR: 0→RTI.
  - RTI: 1→SEL_DR.
  - SEL_DR: 0→CAP_DR, 1→SEL_IR.
  - SEL_IR: 0→CAP_IR, 1→TLR.
  - CAP: 0→SH, 1→EX1.
  - SH: 1→EX1.
  - EX1: 0→PAU, 1→UPD.
  - PAU: 1→EX2.
  - EX2: 0→SH, 1→UPD.
  - UPD: 0→RTI, 1→SEL_DR.
  - Every unlisted branch stays in the current state.
- Strobes are Moore decodes of the current state (combinational from the state register, no extra latency).
- IR shift register `ir_sh`:
  - CAP_IR loads 5'b00001.
  - SH_IR performs `ir_sh <= {tdi, ir_sh[IR_W-1:1]}`.
  - UPD_IR copies `ir_sh` to `ir`.
  - TLR forces `ir = IR_RESET`.
- Decode of `ir` to `sel`; codes and select values live in `etap_constants.vh`:

  | `ir` | instruction | `sel` |
  |---|---|---|
  | 01 | IDCODE | 0 |
  | 03 | IMPCODE | 1 |
  | 08 | ADDRESS | 2 |
  | 09 | DATA | 3 |
  | 0A | CONTROL | 4 |
  | 0C | EJTAGBOOT | 5 |
  | 02 | SAMPLE_PRELOAD | 6 |
  | 1F | BYPASS | 7 |
  | any other | — | 7 (BYPASS) |

- `sel` is a registered copy of the decode; it changes only on the cycle after UPD_IR or on TLR entry.

## Timing
- Reset (`resetn`=0 at a rising edge):
  - state=TLR, `ir`=IR_RESET, `ir_sh`=0, `sel`=0.
  - `tdo`=0, `tdo_en`=0.
  - Strobes at reset: all 0 except `tlr`=1.
- Reset mid-scan aborts immediately and discards the partial `ir_sh`; `ir` is not updated.
- `tdo`/`tdo_en` are registered, one cycle latency:
  - In SH_IR: `tdo <= ir_sh[0]`.
  - In SH_DR: `tdo <= dr_tdo`.
  - Elsewhere: `tdo` holds and `tdo_en <= 0`.
  - `tdo_en <= 1` exactly when the state is SH_IR or SH_DR.
- Five consecutive `tms`=1 cycles reach TLR from any state.
- Entering TLR from any state resets `ir`/`sel` in the same edge the state becomes TLR.
- UPD_IR and a reset on the same edge: reset wins.
- `sel` is stable throughout every DR scan; it never changes while in CAP_DR..UPD_DR.

## Structure
- State enum `tap_state_t` (4-bit), IR opcodes, and `SEL_*` values go in the shared `etap_constants.vh` / package, shared with `mux_dr`.
- Natural sub-module: `tap_fsm` (state register plus next-state logic, output `tap_state_t`).
- IR shift/latch/decode stays in the top.

## Test plan
- **Reset:** `resetn`=0 for 2 cycles, then idle `tms`=0.
  - Expect state RTI after 1 cycle, `ir`=5'h01, `sel`=0, `tdo_en`=0.
- **IR scan DATA:** path TLR→RTI→SEL_DR→SEL_IR→CAP_IR→SH_IR, shift `tdi`=1,0,0,1,0 (LSB first), exit, UPD_IR.
  - Expect `ir`=5'h09 and `sel`=3 one cycle after UPD_IR.
  - Expect `tdo` sequence 1,0,0,0,0 (captured 00001).
- **Unknown opcode:** load 5'h15.
  - Expect `sel`=7.
- **DR scan:** with `sel`=3, shift 32 cycles.
  - Expect `clk_dr`=1 on CAP_DR plus 32 shift cycles.
  - Expect `shift_dr`=1 for exactly 32 cycles and `update_dr` a single 1-cycle pulse.
  - Expect `tdo` to follow `dr_tdo` delayed by 1 cycle.
- **Pause/resume:** SH_DR→EX1→PAU (3 cycles)→EX2→SH_DR.
  - Expect `shift_dr`=0 during the pause, `tdo_en`=0 after one cycle, `sel` unchanged.
- **Escape/reset abort:**
  - `tms`=1 for 5 cycles from SH_IR mid-scan: expect TLR, `ir`=5'h01, `sel`=0, `tlr`=1.
  - Separately, `resetn`=0 during UPD_IR: expect `ir` to remain 5'h01.

Source files
------------

// File: rtl/etap_tap_ctrl_pkg.sv
// Shared EJTAG TAP definitions: state encoding, instruction opcodes and DR select codes.
// The select codes are shared with mux_dr, so keep them in sync with that block.
package etap_tap_ctrl_pkg;

    typedef logic [3:0] tap_state_t;

    localparam tap_state_t TLR    = 4'd0;
    localparam tap_state_t RTI    = 4'd1;
    localparam tap_state_t SEL_DR = 4'd2;
    localparam tap_state_t CAP_DR = 4'd3;
    localparam tap_state_t SH_DR  = 4'd4;
    localparam tap_state_t EX1_DR = 4'd5;
    localparam tap_state_t PAU_DR = 4'd6;
    localparam tap_state_t EX2_DR = 4'd7;
    localparam tap_state_t UPD_DR = 4'd8;
    localparam tap_state_t SEL_IR = 4'd9;
    localparam tap_state_t CAP_IR = 4'd10;
    localparam tap_state_t SH_IR  = 4'd11;
    localparam tap_state_t EX1_IR = 4'd12;
    localparam tap_state_t PAU_IR = 4'd13;
    localparam tap_state_t EX2_IR = 4'd14;
    localparam tap_state_t UPD_IR = 4'd15;

    localparam logic [4:0] IR_IDCODE         = 5'h01;
    localparam logic [4:0] IR_SAMPLE_PRELOAD = 5'h02;
    localparam logic [4:0] IR_IMPCODE        = 5'h03;
    localparam logic [4:0] IR_ADDRESS        = 5'h08;
    localparam logic [4:0] IR_DATA           = 5'h09;
    localparam logic [4:0] IR_CONTROL        = 5'h0A;
    localparam logic [4:0] IR_EJTAGBOOT      = 5'h0C;
    localparam logic [4:0] IR_BYPASS         = 5'h1F;

    localparam logic [3:0] SEL_IDCODE         = 4'd0;
    localparam logic [3:0] SEL_IMPCODE        = 4'd1;
    localparam logic [3:0] SEL_ADDRESS        = 4'd2;
    localparam logic [3:0] SEL_DATA           = 4'd3;
    localparam logic [3:0] SEL_CONTROL        = 4'd4;
    localparam logic [3:0] SEL_EJTAGBOOT      = 4'd5;
    localparam logic [3:0] SEL_SAMPLE_PRELOAD = 4'd6;
    localparam logic [3:0] SEL_BYPASS         = 4'd7;

    // Unrecognised opcodes fall back to BYPASS so the chain length stays defined.
    function automatic logic [3:0] ir_decode(input logic [4:0] code);
        logic [3:0] sel;
        case (code)
            IR_IDCODE:         sel = SEL_IDCODE;
            IR_IMPCODE:        sel = SEL_IMPCODE;
            IR_ADDRESS:        sel = SEL_ADDRESS;
            IR_DATA:           sel = SEL_DATA;
            IR_CONTROL:        sel = SEL_CONTROL;
            IR_EJTAGBOOT:      sel = SEL_EJTAGBOOT;
            IR_SAMPLE_PRELOAD: sel = SEL_SAMPLE_PRELOAD;
            default:           sel = SEL_BYPASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/etap_tap_ctrl_if.sv
// DR-side link between the TAP controller (master) and mux_dr (slave).
interface etap_tap_ctrl_if;
    logic       capture_dr;
    logic       shift_dr;
    logic       clk_dr;
    logic       update_dr;
    logic [3:0] sel;
    logic       dr_tdo;

    modport master (
        output capture_dr,
        output shift_dr,
        output clk_dr,
        output update_dr,
        output sel,
        input  dr_tdo
    );

    modport slave (
        input  capture_dr,
        input  shift_dr,
        input  clk_dr,
        input  update_dr,
        input  sel,
        output dr_tdo
    );
endinterface

// File: rtl/etap_tap_ctrl_fsm.sv
// IEEE 1149.1 16-state TAP state machine; exposes both the current and next state
// so the top can act on the edge that enters Test-Logic-Reset.
module etap_tap_ctrl_fsm
    import etap_tap_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       tms_i,
    output tap_state_t state_o,
    output tap_state_t state_d_o
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    if (!tms_i) state_d = RTI;
            RTI:    if (tms_i)  state_d = SEL_DR;
            SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:  if (tms_i)  state_d = EX1_DR;
            EX1_DR: state_d = tms_i ? UPD_DR : PAU_DR;
            PAU_DR: if (tms_i)  state_d = EX2_DR;
            EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms_i ? SEL_DR : RTI;
            SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:  if (tms_i)  state_d = EX1_IR;
            EX1_IR: state_d = tms_i ? UPD_IR : PAU_IR;
            PAU_IR: if (tms_i)  state_d = EX2_IR;
            EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms_i ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o   = state_q;
    assign state_d_o = state_d;

endmodule

// File: rtl/etap_tap_ctrl.sv
// EJTAG TAP controller front end: FSM, instruction register with decode to the DR
// select, Moore DR strobes and the registered serial output.
module etap_tap_ctrl
    import etap_tap_ctrl_pkg::*;
#(
    parameter int              IR_W     = 5,
    parameter logic [IR_W-1:0] IR_RESET = 5'h01
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            tms_i,
    input  logic            tdi_i,
    etap_tap_ctrl_if.master dr_if,
    output logic            tdo_o,
    output logic            tdo_en_o,
    output logic [IR_W-1:0] ir_o,
    output logic            tlr_o
);

    localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-1){1'b0}}, 1'b1};

    tap_state_t state;
    tap_state_t state_d;

    logic [IR_W-1:0] ir_sh_q, ir_sh_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [3:0]      sel_q, sel_d;
    logic            tdo_q, tdo_d;
    logic            tdo_en_q, tdo_en_d;

    etap_tap_ctrl_fsm u_fsm (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .tms_i     (tms_i),
        .state_o   (state),
        .state_d_o (state_d)
    );

    // Moving into TLR overrides any latch so the IR is already IDCODE once TLR is visible.
    always_comb begin
        ir_sh_d = ir_sh_q;
        ir_d    = ir_q;
        sel_d   = sel_q;
        case (state)
            CAP_IR: ir_sh_d = IR_CAPTURE;
            SH_IR:  ir_sh_d = {tdi_i, ir_sh_q[IR_W-1:1]};
            UPD_IR: begin
                ir_d  = ir_sh_q;
                sel_d = ir_decode(ir_sh_q);
            end
            default: ;
        endcase
        if (state_d == TLR) begin
            ir_d  = IR_RESET;
            sel_d = SEL_IDCODE;
        end
    end

    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        case (state)
            SH_IR: begin
                tdo_d    = ir_sh_q[0];
                tdo_en_d = 1'b1;
            end
            SH_DR: begin
                tdo_d    = dr_if.dr_tdo;
                tdo_en_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            ir_sh_q  <= '0;
            ir_q     <= IR_RESET;
            sel_q    <= SEL_IDCODE;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            ir_sh_q  <= ir_sh_d;
            ir_q     <= ir_d;
            sel_q    <= sel_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign dr_if.capture_dr = (state == CAP_DR);
    assign dr_if.shift_dr   = (state == SH_DR);
    assign dr_if.clk_dr     = (state == CAP_DR) || (state == SH_DR);
    assign dr_if.update_dr  = (state == UPD_DR);
    assign dr_if.sel        = sel_q;

    assign tdo_o    = tdo_q;
    assign tdo_en_o = tdo_en_q;
    assign ir_o     = ir_q;
    assign tlr_o    = (state == TLR);

endmodule
